l2_line_burst_adaptor: RTL and testbench

- Memory-side responder for the L2 cache's line-granular handshake (`pmem_read` / `pmem_write` / `pmem_resp`).
- Converts each 256-bit line read or write into a 4-beat, 64-bit burst on the physical-memory bus.
- Aligns and holds the address and line data while the burst runs.
- Returns a single-cycle line-level response to the L2 controller.

---
 rtl/l2_line_burst_adaptor.sv | 158 +++++++++++++++
 tb/tb_l2_line_burst_adaptor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_line_burst_adaptor.sv
// -----------------------------------------------------------------------------
// l2_line_burst_adaptor
//
// Memory-side responder for the L2 cache line handshake. Each line read or
// write is turned into a BEATS-long burst of BEAT_W-bit beats on the
// physical-memory bus. A single-cycle line_resp goes back to the L2 when the
// burst completes.
//
// Optional feature macro: LINE_ADAPTOR_FAST_RESP_EN
//   undefined : the response is registered and issued from a DONE state one
//               cycle after the last beat.
//   defined   : DONE is skipped. line_resp is asserted combinationally with
//               the last burst_resp. The top read slice is forwarded straight
//               from burst_rdata in that cycle, which saves one cycle.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   line_addr         line address from L2 (sampled in IDLE only)
//   line_read         L2 pmem_read
//   line_write        L2 pmem_write (wins over line_read)
//   line_wdata        line to write back (sampled in IDLE only)
//   line_rdata        assembled read line, held until the next read overwrites it
//   line_resp         L2 pmem_resp, one cycle per line transaction
//   burst_addr        line-aligned burst address
//   burst_read        burst read request (decoded from state)
//   burst_write       burst write request (decoded from state)
//   burst_wdata       current write beat
//   burst_rdata       current read beat
//   burst_resp        per-beat acknowledge from memory
// -----------------------------------------------------------------------------
module l2_line_burst_adaptor #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic [ADDR_W-1:0] burst_addr,
    output logic              burst_read,
    output logic              burst_write,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_resp
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Byte-offset bits inside one line; cleared to align the burst address.
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

`ifdef LINE_ADAPTOR_FAST_RESP_EN
    localparam state_t END_STATE = IDLE;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BEAT_W-1:0] rbuf_q [BEATS];
    logic [BEAT_W-1:0] wbuf_q [BEATS];

    // Single FSM block: request capture, beat counting and buffer updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            for (int i = 0; i < BEATS; i++) begin
                rbuf_q[i] <= '0;
                wbuf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (line_write || line_read) begin
                        addr_q <= {line_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        cnt_q  <= '0;
                        if (line_write) begin
                            for (int i = 0; i < BEATS; i++) begin
                                wbuf_q[i] <= line_wdata[i*BEAT_W +: BEAT_W];
                            end
                            state_q <= WR_BURST;
                        end else begin
                            state_q <= RD_BURST;
                        end
                    end
                end
                RD_BURST: begin
                    if (burst_resp) begin
                        rbuf_q[cnt_q] <= burst_rdata;
                        cnt_q         <= cnt_q + 1'b1;   // wraps 3->0 on the last beat
                        if (cnt_q == LAST_BEAT) begin
                            state_q <= END_STATE;
                        end
                    end
                end
                WR_BURST: begin
                    if (burst_resp) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BEAT) begin
                            state_q <= END_STATE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Request strobes depend on state alone, so they cannot glitch and they
    // drop as soon as reset forces IDLE.
    assign burst_addr  = addr_q;
    assign burst_read  = (state_q == RD_BURST);
    assign burst_write = (state_q == WR_BURST);
    assign burst_wdata = wbuf_q[cnt_q];

`ifdef LINE_ADAPTOR_FAST_RESP_EN
    // This cycle's acknowledge completes the burst.
    logic last_beat;
    assign last_beat = burst_resp && (cnt_q == LAST_BEAT) &&
                       ((state_q == RD_BURST) || (state_q == WR_BURST));
    assign line_resp = last_beat;
`else
    assign line_resp = (state_q == DONE);
`endif

    // Assemble the read line from the beat registers. In fast mode the top
    // slice is bypassed from the bus during the final read beat, so the line
    // is complete in the same cycle as line_resp.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_rdata
`ifdef LINE_ADAPTOR_FAST_RESP_EN
        if (gi == BEATS - 1) begin : g_bypass
            assign line_rdata[gi*BEAT_W +: BEAT_W] =
                (last_beat && (state_q == RD_BURST)) ? burst_rdata : rbuf_q[gi];
        end else begin : g_reg
            assign line_rdata[gi*BEAT_W +: BEAT_W] = rbuf_q[gi];
        end
`else
        assign line_rdata[gi*BEAT_W +: BEAT_W] = rbuf_q[gi];
`endif
    end

endmodule

// File: tb/tb_l2_line_burst_adaptor.sv
`timescale 1ns/1ps
module tb_l2_line_burst_adaptor;

`ifdef LINE_ADAPTOR_FAST_RESP_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  line_addr;
    logic         line_read;
    logic         line_write;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic [31:0]  burst_addr;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int checks = 0;
    int failures = 0;

    // Last line that a completed read delivered. It is cleared by reset and
    // left unchanged by writes.
    logic [255:0] model_rdata;

    l2_line_burst_adaptor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_addr   (line_addr),
        .line_read   (line_read),
        .line_write  (line_write),
        .line_wdata  (line_wdata),
        .line_rdata  (line_rdata),
        .line_resp   (line_resp),
        .burst_addr  (burst_addr),
        .burst_read  (burst_read),
        .burst_write (burst_write),
        .burst_wdata (burst_wdata),
        .burst_rdata (burst_rdata),
        .burst_resp  (burst_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got running, required finished)");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rline;
        int           gap;
        logic [31:0]  exp_addr;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full line transaction. Memory acknowledges each beat after `gap`
    // stall cycles; a negative gap picks a random stall per beat. The request
    // is held until line_resp, as the L2 controller does. Unrelated line_*
    // values are scrambled while the burst runs.
    task automatic run_txn(input string name, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [255:0] wdata,
                           input logic [255:0] rline, input int gap,
                           input logic [31:0] exp_addr);
        int beat;
        int wait_c;
        int cur_gap;
        bit done;
        bit ack;
        bit exp_resp;
        logic [255:0] exp_line;
        beat = 0;
        wait_c = 0;
        done = 1'b0;
        exp_line = wr ? model_rdata : rline;
        cur_gap = (gap < 0) ? int'($urandom_range(0, 3)) : gap;

        // Cycle 0: the request is presented while the DUT is idle.
        line_addr = addr;
        line_read = rd;
        line_write = wr;
        line_wdata = wdata;
        burst_resp = 1'b0;
        #1;
        chk($sformatf("%s/idle_resp", name), 256'(line_resp), 256'(0));
        chk($sformatf("%s/idle_req", name), 256'(burst_read | burst_write), 256'(0));
        @(posedge clk); #1;

        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            ack = (beat < 4) && (wait_c >= cur_gap);
            burst_resp = ack;
            burst_rdata = ack ? rline[beat*64 +: 64] : {$urandom, $urandom};
            line_addr = $urandom;
            line_wdata = rand256();
            #1;
            if (beat < 4) begin
                exp_resp = FAST && ack && (beat == 3);
                chk($sformatf("%s/burst_read b%0d", name, beat), 256'(burst_read), 256'(!wr));
                chk($sformatf("%s/burst_write b%0d", name, beat), 256'(burst_write), 256'(wr));
                chk($sformatf("%s/burst_addr b%0d", name, beat), 256'(burst_addr), 256'(exp_addr));
                if (wr) begin
                    chk($sformatf("%s/burst_wdata b%0d", name, beat), 256'(burst_wdata),
                        256'(wdata[beat*64 +: 64]));
                end
                chk($sformatf("%s/line_resp b%0d", name, beat), 256'(line_resp), 256'(exp_resp));
                if (exp_resp) begin
                    chk($sformatf("%s/line_rdata fast", name), line_rdata, exp_line);
                end
            end else begin
                // This is the cycle right after the last beat.
                chk($sformatf("%s/line_resp done", name), 256'(line_resp), 256'(1));
                chk($sformatf("%s/req_drop done", name), 256'(burst_read | burst_write), 256'(0));
                chk($sformatf("%s/line_rdata done", name), line_rdata, exp_line);
                done = 1'b1;
            end
            if (ack) begin
                beat++;
                wait_c = 0;
                cur_gap = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            end else begin
                wait_c++;
            end
            if (FAST && beat == 4) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s/timeout: got no line_resp required line_resp within 100 cycles", name);
        end
        model_rdata = exp_line;

        // The DUT is idle again. The request is dropped, and a spurious ack
        // must be ignored.
        line_read = 1'b0;
        line_write = 1'b0;
        burst_resp = 1'b1;
        burst_rdata = {$urandom, $urandom};
        #1;
        chk($sformatf("%s/after_resp", name), 256'(line_resp), 256'(0));
        chk($sformatf("%s/after_req", name), 256'(burst_read | burst_write), 256'(0));
        chk($sformatf("%s/after_rdata", name), line_rdata, model_rdata);
        @(posedge clk); #1;
        burst_resp = 1'b0;
        $display("txn %s: rd=%0b wr=%0b addr=%h burst_addr=%h rdata=%h",
                 name, rd, wr, addr, exp_addr, model_rdata);
    endtask

    initial begin
        vec_t vecs[5];
        bit r;
        bit w;
        int op;
        logic [31:0] a;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 256'h0,
                    {64'hA3A3_0000_0000_00A3, 64'hA2A2_0000_0000_00A2,
                     64'hA1A1_0000_0000_00A1, 64'hA0A0_0000_0000_00A0},
                    0, 32'h0000_1220};
        vecs[1] = '{1'b0, 1'b1, 32'hDEAD_BEEF,
                    {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
                     64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000},
                    {4{64'h5555_5555_5555_5555}}, 2, 32'hDEAD_BEE0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_003F,
                    {64'hC3, 64'hC2, 64'hC1, 64'hC0},
                    {4{64'hEEEE_EEEE_EEEE_EEEE}}, 1, 32'h0000_0020};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 256'h0,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001},
                    1, 32'hFFFF_FFE0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0000, 256'h0,
                    {64'h4, 64'h3, 64'h2, 64'h1}, 3, 32'h0000_0000};

        line_addr = '0;
        line_read = 1'b0;
        line_write = 1'b0;
        line_wdata = '0;
        burst_rdata = '0;
        burst_resp = 1'b0;
        model_rdata = '0;

        // The outputs must show their reset values while reset is held.
        #2;
        chk("reset/line_resp", 256'(line_resp), 256'(0));
        chk("reset/burst_read", 256'(burst_read), 256'(0));
        chk("reset/burst_write", 256'(burst_write), 256'(0));
        chk("reset/burst_addr", 256'(burst_addr), 256'(0));
        chk("reset/line_rdata", line_rdata, 256'(0));
        chk("reset/burst_wdata", 256'(burst_wdata), 256'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Acknowledges that arrive while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            burst_resp = 1'b1;
            burst_rdata = {$urandom, $urandom};
            #1;
            chk($sformatf("spurious%0d/line_resp", i), 256'(line_resp), 256'(0));
            chk($sformatf("spurious%0d/req", i), 256'(burst_read | burst_write), 256'(0));
            @(posedge clk); #1;
        end
        burst_resp = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                    vecs[i].wdata, vecs[i].rline, vecs[i].gap, vecs[i].exp_addr);
        end

        // Reset after two beats of a read: outputs clear at once, with no edge.
        line_addr = 32'h0000_5678;
        line_read = 1'b1;
        line_write = 1'b0;
        burst_resp = 1'b0;
        @(posedge clk); #1;
        for (int b = 0; b < 2; b++) begin
            burst_resp = 1'b1;
            burst_rdata = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        chk("midrst/in_burst", 256'(burst_read), 256'(1));
        burst_resp = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst/burst_read", 256'(burst_read), 256'(0));
        chk("midrst/burst_write", 256'(burst_write), 256'(0));
        chk("midrst/line_resp", 256'(line_resp), 256'(0));
        chk("midrst/burst_addr", 256'(burst_addr), 256'(0));
        chk("midrst/line_rdata", line_rdata, 256'(0));
        chk("midrst/burst_wdata", 256'(burst_wdata), 256'(0));
        burst_resp = 1'b0;
        line_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_rdata = '0;
        $display("txn midrst: read to 00005678 truncated by reset after 2 beats");
        run_txn("post_reset", 1'b1, 1'b0, 32'h0000_9ABC, rand256(), rand256(), 0, 32'h0000_9AA0);

        // Random traffic is checked against the transaction-level model.
        for (int t = 0; t < 40; t++) begin
            op = int'($urandom_range(0, 2));
            r = (op != 1);
            w = (op != 0);
            a = $urandom;
            run_txn($sformatf("rand%0d", t), r, w, a, rand256(), rand256(), -1,
                    a & 32'hFFFF_FFE0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
